// File: rtl/line_tx_sched.sv
// line_tx_sched: frame-locked row scheduler feeding the line buffer -> UDP path.
// Each frame it requests rows 0, ROW_STEP, 2*ROW_STEP, ... one at a time. It waits
// for each transfer to complete or time out, then holds a pacing gap before the
// next request.
// Optional feature: define LINE_SCHED_RETRY_EN to re-issue a failed row up to
// MAX_RETRY times before dropping it.
// All outputs are registered. lb_trig trails the ISSUE state by one cycle, so
// frame_sync -> lb_trig is 2 cycles and lb_done -> next lb_trig is GAP_CYCLES+2.
module line_tx_sched #(
  parameter int V_ACT      = 720,
  parameter int ROW_STEP   = 1,
  parameter int GAP_CYCLES = 1000,
  parameter int TIMEOUT    = 200000,
  parameter int MAX_RETRY  = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     frame_sync_i,
  input  logic                     cam_alt_i,
  output logic                     lb_trig_o,
  output logic [$clog2(V_ACT)-1:0] lb_row_o,
  output logic                     lb_cam_sel_o,
  input  logic                     lb_done_i,
  input  logic                     lb_err_i,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int RW      = $clog2(V_ACT);
  localparam int GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int TMAX    = (TIMEOUT > GAP_LEN) ? TIMEOUT : GAP_LEN;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   row_q, row_d;
  logic            cam_q, cam_d;
  logic [15:0]     drop_q, drop_d;
  logic            trig_q, trig_d;
  logic            busy_q, busy_d;
  logic            fdone_q, fdone_d;

  logic            start, fail, ok, gap_end, last;
  logic            retry_pend, drop_now;
  logic [RW:0]     next_row;

  // Events of the current cycle; a simultaneous lb_err beats lb_done.
  assign start    = (state_q == S_WAIT_FRAME) && enable_i && frame_sync_i;
  assign fail     = (state_q == S_WAIT_DONE) &&
                    (lb_err_i || (!lb_done_i && timer_q == TW'(TIMEOUT - 1)));
  assign ok       = (state_q == S_WAIT_DONE) && lb_done_i && !lb_err_i;
  assign gap_end  = (state_q == S_GAP) && (timer_q == TW'(GAP_LEN - 1));
  // One extra bit so the last step past V_ACT cannot wrap back into range.
  assign next_row = {1'b0, row_q} + (RW+1)'(ROW_STEP);
  assign last     = next_row >= (RW+1)'(V_ACT);

`ifdef LINE_SCHED_RETRY_EN
  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [CW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d;

  assign retry_pend = pend_q;
  assign drop_now   = fail && (retry_q == CW'(MAX_RETRY));

  // Retry bookkeeping: a failure under budget marks the row for re-issue.
  always_comb begin
    retry_d = retry_q;
    pend_d  = pend_q;
    if (start) begin
      retry_d = '0;
      pend_d  = 1'b0;
    end else if (fail && !drop_now) begin
      retry_d = retry_q + 1'b1;
      pend_d  = 1'b1;
    end else if (gap_end) begin
      pend_d = 1'b0;
      if (!pend_q) retry_d = '0;
    end
  end

  // Retry registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      retry_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      retry_q <= retry_d;
      pend_q  <= pend_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_RETRY < 0);
  assign retry_pend = 1'b0;
  assign drop_now   = fail;
`endif

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      row_q   <= '0;
      cam_q   <= 1'b0;
      drop_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      cam_q   <= cam_d;
      drop_q  <= drop_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  // Next-state: enable only takes effect while idle-ish or at the end of a gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (enable_i) state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (!enable_i)         state_d = S_IDLE;
        else if (frame_sync_i) state_d = S_ISSUE;
      end
      S_ISSUE:      state_d = S_WAIT_DONE;
      S_WAIT_DONE:  if (fail || ok) state_d = S_GAP;
      S_GAP: begin
        if (gap_end) begin
          if (!enable_i)       state_d = S_IDLE;
          else if (retry_pend) state_d = S_ISSUE;
          else if (last)       state_d = S_WAIT_FRAME;
          else                 state_d = S_ISSUE;
        end
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; the timer restarts on every state change.
  always_comb begin
    timer_d = '0;
    row_d   = row_q;
    cam_d   = cam_q;
    drop_d  = drop_q;
    fdone_d = 1'b0;
    trig_d  = (state_q == S_ISSUE);
    busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT_DONE) || (state_d == S_GAP);
    if ((state_d == S_WAIT_DONE || state_d == S_GAP) && state_d == state_q)
      timer_d = timer_q + 1'b1;
    if (start) row_d = '0;
    if (gap_end && !retry_pend) begin
      if (last) begin
        fdone_d = 1'b1;
        if (cam_alt_i) cam_d = ~cam_q;
      end else if (enable_i) begin
        row_d = next_row[RW-1:0];
      end
    end
    if (drop_now && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  assign lb_trig_o    = trig_q;
  assign lb_row_o     = row_q;
  assign lb_cam_sel_o = cam_q;
  assign busy_o       = busy_q;
  assign frame_done_o = fdone_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_line_tx_sched.sv
// Self-checking bench for line_tx_sched: directed scenarios plus a randomized run,
// all compared every cycle against a timestamp-based behavioural model.
module tb_line_tx_sched;
  localparam int V_ACT = 4, ROW_STEP = 1, GAP_CYCLES = 3, TIMEOUT = 16, MAX_RETRY = 2;
  localparam int RW = $clog2(V_ACT);
  localparam int GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

  logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, frame_sync = 1'b0, cam_alt = 1'b0;
  logic lb_done = 1'b0, lb_err = 1'b0;
  logic lb_trig, lb_cam_sel, busy, frame_done;
  logic [RW-1:0] lb_row;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  line_tx_sched #(.V_ACT(V_ACT), .ROW_STEP(ROW_STEP), .GAP_CYCLES(GAP_CYCLES),
                  .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .frame_sync_i(frame_sync),
    .cam_alt_i(cam_alt), .lb_trig_o(lb_trig), .lb_row_o(lb_row),
    .lb_cam_sel_o(lb_cam_sel), .lb_done_i(lb_done), .lb_err_i(lb_err),
    .busy_o(busy), .frame_done_o(frame_done), .drop_cnt_o(drop_cnt));

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks a frame as timestamps: the cycle of each request pulse, the cycle the
  // transfer resolved, and derives everything else from those.
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2;
  int  m_mode = M_IDLE, m_row = 0, m_drop = 0, m_retries = 0;
  int  m_tc = 0, t_trig = 0, t_res = -1;
  bit  m_pend = 0, m_cam = 0, m_trig = 0, m_busy = 0, m_fd = 0, m_valid = 0;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_mode = M_IDLE; m_row = 0; m_drop = 0; m_retries = 0; m_pend = 0;
      m_cam = 0; m_trig = 0; m_busy = 0; m_fd = 0; t_res = -1; m_valid = 1;
    end else begin
      int p;
      bit en, fs, ca, dn, er, lst, fl;
      p = m_tc; m_tc++;
      en = enable; fs = frame_sync; ca = cam_alt; dn = lb_done; er = lb_err;
      m_fd = 0; m_trig = 0;
      case (m_mode)
        M_IDLE:  if (en) m_mode = M_ARMED;
        M_ARMED: begin
          if (!en) m_mode = M_IDLE;
          else if (fs) begin
            m_mode = M_RUN; m_row = 0; m_retries = 0; m_pend = 0;
            t_trig = p + 2; t_res = -1;
          end
        end
        default: begin
          if (t_res < 0 && p >= t_trig) begin
            fl = er || (!dn && p == t_trig + TIMEOUT - 1);
            if (fl || dn) t_res = p;
            if (fl) begin
`ifdef LINE_SCHED_RETRY_EN
              if (m_retries < MAX_RETRY) begin m_retries++; m_pend = 1; end
              else if (m_drop < 65535) m_drop++;
`else
              if (m_drop < 65535) m_drop++;
`endif
            end
          end else if (t_res >= 0 && p == t_res + GAP_LEN) begin
            lst = (m_row + ROW_STEP) >= V_ACT;
            if (!m_pend && lst) begin m_fd = 1; if (ca) m_cam = ~m_cam; end
            if (!en) m_mode = M_IDLE;
            else if (m_pend) begin t_trig = p + 2; t_res = -1; end
            else if (lst) m_mode = M_ARMED;
            else begin m_row += ROW_STEP; m_retries = 0; t_trig = p + 2; t_res = -1; end
            m_pend = 0;
          end
        end
      endcase
      m_busy = (m_mode == M_RUN);
      m_trig = (m_mode == M_RUN) && (m_tc == t_trig);
    end
  end

  // ---------------- compare + monitor ----------------
  int tr_row[$];
  int tr_cyc[$];
  int fd_cnt = 0;
  always @(negedge clk) begin
    if (rstn && m_valid) begin
      chk("trig",  lb_trig,    m_trig);
      chk("row",   lb_row,     m_row);
      chk("cam",   lb_cam_sel, m_cam);
      chk("busy",  busy,       m_busy);
      chk("fdone", frame_done, m_fd);
      chk("drop",  drop_cnt,   m_drop);
    end
    if (rstn && lb_trig === 1'b1) begin tr_row.push_back(int'(lb_row)); tr_cyc.push_back(cyc); end
    if (rstn && frame_done === 1'b1) fd_cnt++;
  end

  // ---------------- line-buffer responder ----------------
  // r_mode: 0 fixed delay, 1 random (errors/timeouts/spurious), 2 never answer
  // row r_skip, 3 err+done together on row 0.
  int r_mode = 0, r_delay = 5, r_skip = 1, cd = 0;
  bit p_done = 0, p_err = 0;
  initial forever begin
    @(negedge clk);
    if (!rstn) cd = 0;
    else if (lb_trig === 1'b1) begin
      int x;
      cd = r_delay; p_done = 1; p_err = 0;
      case (r_mode)
        1: begin
          cd = $urandom_range(1, 20); x = $urandom_range(0, 99);
          p_err = (x < 15); p_done = (x >= 10);
        end
        2: if (int'(lb_row) == r_skip) cd = 0;
        3: if (lb_row == '0) p_err = 1;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    lb_done = 0; lb_err = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin lb_done = p_done; lb_err = p_err; end
    end
    if (r_mode == 1 && $urandom_range(0, 99) < 2) lb_done = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_fs();
    frame_sync = 1; step(); frame_sync = 0;
  endtask
  task automatic wait_trig(input int target, input string nm);
    int i = 0;
    while (tr_row.size() < target && i < 400) begin step(); i++; end
    chk(nm, tr_row.size() >= target, 1);
  endtask
  task automatic wait_fd(input int f0, input string nm);
    int i = 0;
    while (fd_cnt == f0 && i < 400) begin step(); i++; end
    chk(nm, fd_cnt > f0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0, d0, fs_c, c1, c2, cnt, exp_iss;
    rstn = 0;
    step(3);
    chk("rst_trig", lb_trig, 0); chk("rst_row", lb_row, 0); chk("rst_cam", lb_cam_sel, 0);
    chk("rst_busy", busy, 0); chk("rst_fd", frame_done, 0); chk("rst_drop", drop_cnt, 0);
    rstn = 1;
    step(2);

    // 1: plain frame
    enable = 1; r_mode = 0; r_delay = 5;
    step(3);
    n0 = tr_row.size(); f0 = fd_cnt; fs_c = cyc;
    pulse_fs();
    wait_fd(f0, "t1_frame_done");
    step(2);
    chk("t1_ntrig", tr_row.size() - n0, 4);
    if (tr_row.size() - n0 >= 4) begin
      for (int i = 0; i < 4; i++) chk("t1_row_seq", tr_row[n0+i], i);
      chk("t1_lat_fs", tr_cyc[n0] - fs_c, 2);
      chk("t1_lat_done", tr_cyc[n0+1] - tr_cyc[n0], 10);
    end
    chk("t1_fd_once", fd_cnt - f0, 1);
    chk("t1_drop", drop_cnt, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_model_drop", m_drop, 0);

    // 2: camera alternation
    cam_alt = 1;
    n0 = tr_row.size(); f0 = fd_cnt;
    pulse_fs(); wait_trig(n0 + 1, "t2_trig_f1");
    chk("t2_cam_f1", lb_cam_sel, 0);
    wait_fd(f0, "t2_fd_f1"); step();
    n0 = tr_row.size(); f0 = fd_cnt;
    pulse_fs(); wait_trig(n0 + 1, "t2_trig_f2");
    chk("t2_cam_f2", lb_cam_sel, 1);
    wait_fd(f0, "t2_fd_f2"); step();
    chk("t2_cam_after", lb_cam_sel, 0);
    cam_alt = 0; f0 = fd_cnt;
    pulse_fs(); wait_fd(f0, "t2_fd_f3"); step();
    chk("t2_cam_const", lb_cam_sel, 0);

    // 3: row 1 never answered
    r_mode = 2; r_skip = 1;
    n0 = tr_row.size(); f0 = fd_cnt; d0 = drop_cnt;
    pulse_fs(); wait_fd(f0, "t3_fd"); step(2);
`ifdef LINE_SCHED_RETRY_EN
    exp_iss = MAX_RETRY + 1;
`else
    exp_iss = 1;
`endif
    cnt = 0; c1 = -1; c2 = -1;
    for (int i = n0; i < tr_row.size(); i++) begin
      if (tr_row[i] == 1) begin cnt++; if (c1 < 0) c1 = tr_cyc[i]; end
      if (tr_row[i] == 2 && c2 < 0) c2 = tr_cyc[i];
    end
    chk("t3_row1_issues", cnt, exp_iss);
    chk("t3_drop", drop_cnt - d0, 1);
    chk("t3_row2_spacing", c2 - c1, exp_iss * (TIMEOUT + GAP_CYCLES + 1));
    chk("t3_model_drop", m_drop, 1);

    // 4: err and done together on row 0
    r_mode = 3;
    n0 = tr_row.size(); f0 = fd_cnt; d0 = drop_cnt;
    pulse_fs(); wait_fd(f0, "t4_fd"); step(2);
    cnt = 0;
    for (int i = n0; i < tr_row.size(); i++) if (tr_row[i] == 0) cnt++;
    chk("t4_row0_issues", cnt, exp_iss);
    chk("t4_drop", drop_cnt - d0, 1);
    chk("t4_model_drop", m_drop, 2);

    // 5: disable mid-frame, frame_sync while busy
    r_mode = 0;
    n0 = tr_row.size(); f0 = fd_cnt;
    pulse_fs(); wait_trig(n0 + 2, "t5_trig_r1");
    pulse_fs();
    wait_trig(n0 + 3, "t5_trig_r2");
    if (tr_row.size() >= n0 + 3) chk("t5_no_restart", tr_row[n0+2], 2);
    enable = 0;
    step(); pulse_fs(); step(2); pulse_fs();
    for (int i = 0; i < 50 && busy === 1'b1; i++) step();
    chk("t5_busy_drop", busy, 0);
    step(30);
    chk("t5_ntrig", tr_row.size() - n0, 3);
    chk("t5_no_fd", fd_cnt - f0, 0);

    // 6: reset mid-WAIT_DONE
    enable = 1; step(2);
    n0 = tr_row.size();
    pulse_fs(); wait_trig(n0 + 1, "t6_trig");
    step(2);
    chk("t6_pre_busy", busy, 1);
    rstn = 0; #1;
    chk("t6_rst_trig", lb_trig, 0); chk("t6_rst_row", lb_row, 0); chk("t6_rst_cam", lb_cam_sel, 0);
    chk("t6_rst_busy", busy, 0); chk("t6_rst_fd", frame_done, 0); chk("t6_rst_drop", drop_cnt, 0);
    step(2); rstn = 1;
    n0 = tr_row.size();
    step(20);
    chk("t6_no_trig", tr_row.size() - n0, 0);
    f0 = fd_cnt;
    pulse_fs(); wait_trig(n0 + 1, "t6_trig_again");
    if (tr_row.size() > n0) chk("t6_row0", tr_row[n0], 0);
    wait_fd(f0, "t6_fd");

    // 7: randomized traffic
    r_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      frame_sync = ($urandom_range(0, 29) == 0);
      if (enable && $urandom_range(0, 199) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
      if ($urandom_range(0, 49) == 0) cam_alt = ~cam_alt;
      step();
    end
    frame_sync = 0; r_mode = 0;
    step(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
